wave_out_stage: RTL and testbench

Output stage placed directly downstream of the wave generators and the DDS core. It selects one of six W-bit sample streams with wave_sel, scales it with amp_sel, and double-buffers it into a duty register. A first-order PWM DAC then turns that value into the single-bit `out` that drives the board pin. Samples are captured on a one-cycle enable strobe generated from the frequency-select carry. The PWM itself runs continuously on clk.

---
 rtl/wave_out_stage.sv | 110 +++++++++++
 tb/tb_wave_out_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_out_stage.sv
// Output stage: selects and scales one of six sample streams, double-buffers it
// into a duty register and drives a first-order PWM DAC onto the board pin.
module wave_out_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         smp_stb,
  input  logic [2:0]   wave_sel,
  input  logic [1:0]   amp_sel,
  input  logic [W-1:0] sine,
  input  logic [W-1:0] full,
  input  logic [W-1:0] half,
  input  logic [W-1:0] recip,
  input  logic [W-1:0] tri_wave,
  input  logic [W-1:0] rect,
  output logic         out,
  output logic         period_start,
  output logic         ovr
);

  localparam logic [2:0] SEL_SINE  = 3'b000;
  localparam logic [2:0] SEL_FULL  = 3'b001;
  localparam logic [2:0] SEL_HALF  = 3'b010;
  localparam logic [2:0] SEL_RECIP = 3'b011;
  localparam logic [2:0] SEL_TRI   = 3'b100;
  localparam logic [2:0] SEL_RECT  = 3'b101;

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt;
  logic [W-1:0] duty;
  logic [W-1:0] pending;
  logic         pend_valid;

  logic [W-1:0] selected_c;
  logic [W-1:0] scaled_c;
  logic         wrap_c;

  logic [W-1:0] cnt_nxt;
  logic [W-1:0] duty_nxt;
  logic [W-1:0] pending_nxt;
  logic         pend_valid_nxt;
  logic         out_nxt;
  logic         period_start_nxt;
  logic         ovr_nxt;

  // Source mux; unused select codes yield silence
  always_comb begin
    selected_c = '0;
    case (wave_sel)
      SEL_SINE:  selected_c = sine;
      SEL_FULL:  selected_c = full;
      SEL_HALF:  selected_c = half;
      SEL_RECIP: selected_c = recip;
      SEL_TRI:   selected_c = tri_wave;
      SEL_RECT:  selected_c = rect;
      default:   selected_c = '0;
    endcase
  end

  assign scaled_c = selected_c >> amp_sel;
  assign wrap_c   = (cnt == CNT_MAX);

  // Next-state: counter, double buffer, overrun flag and PWM compare
  always_comb begin
    cnt_nxt          = cnt + W'(1);
    duty_nxt         = duty;
    pending_nxt      = pending;
    pend_valid_nxt   = pend_valid;
    ovr_nxt          = ovr;
    out_nxt          = (cnt < duty);
    // period_start is registered one edge early so it is high exactly while cnt==0
    period_start_nxt = wrap_c;

    if (wrap_c && pend_valid) begin
      duty_nxt       = pending;
      pend_valid_nxt = 1'b0;
    end

    if (smp_stb) begin
      pending_nxt    = scaled_c;
      pend_valid_nxt = 1'b1;
      if (pend_valid && !wrap_c) begin
        ovr_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      duty         <= '0;
      pending      <= '0;
      pend_valid   <= 1'b0;
      out          <= 1'b0;
      period_start <= 1'b1;
      ovr          <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      duty         <= duty_nxt;
      pending      <= pending_nxt;
      pend_valid   <= pend_valid_nxt;
      out          <= out_nxt;
      period_start <= period_start_nxt;
      ovr          <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_wave_out_stage.sv
// Directed bench for wave_out_stage: tracks the PWM phase itself and checks
// output shape, period_start and the overrun flag against hand-computed duties.
module tb_wave_out_stage;

  logic       clk;
  logic       rst;
  logic       smp_stb;
  logic [2:0] wave_sel;
  logic [1:0] amp_sel;
  logic [7:0] sine, full, half, recip, tri_wave, rect;
  logic       out, period_start, ovr;

  int n_assert;
  int n_fail;
  int tb_cnt;

  wave_out_stage #(.W(8)) dut (
    .clk(clk), .rst(rst), .smp_stb(smp_stb),
    .wave_sel(wave_sel), .amp_sel(amp_sel),
    .sine(sine), .full(full), .half(half), .recip(recip),
    .tri_wave(tri_wave), .rect(rect),
    .out(out), .period_start(period_start), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: edge, then settle to the falling edge where outputs are sampled
  task automatic step();
    @(posedge clk);
    tb_cnt = (tb_cnt + 1) % 256;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    tb_cnt = 0;
  endtask

  task automatic align(input int target);
    int n;
    n = 0;
    while (tb_cnt != target && n < 300) begin
      step();
      n++;
    end
    if (tb_cnt != target) chk("align", 32'(tb_cnt), 32'(target));
  endtask

  task automatic strobe();
    smp_stb = 1'b1;
    step();
    smp_stb = 1'b0;
  endtask

  // Walk one full period from cnt==0; out must be high for cnt 1..duty
  task automatic check_period(input string tag, input int duty);
    int hi, bad;
    hi = 0;
    bad = 0;
    align(0);
    for (int k = 1; k <= 256; k++) begin
      step();
      if (out === 1'b1) hi++;
      if (out !== ((k <= duty) ? 1'b1 : 1'b0)) bad++;
      if (period_start !== ((tb_cnt == 0) ? 1'b1 : 1'b0)) bad++;
    end
    chk({tag, "_hi"}, 32'(hi), 32'(duty));
    chk({tag, "_shape"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int hi, ps_bad, ps_cnt;
    n_assert = 0;
    n_fail   = 0;
    tb_cnt   = 0;
    rst      = 1'b0;
    smp_stb  = 1'b0;
    wave_sel = 3'b000;
    amp_sel  = 2'b00;
    sine = 8'h00; full = 8'h00; half = 8'h00;
    recip = 8'h00; tri_wave = 8'h00; rect = 8'h00;

    // Reset then idle
    do_reset();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd1);
    chk("rst_ovr", 32'(ovr), 32'd0);
    hi = 0; ps_bad = 0; ps_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (out === 1'b1) hi++;
      if (period_start === 1'b1) ps_cnt++;
      if (period_start !== ((tb_cnt == 0) ? 1'b1 : 1'b0)) ps_bad++;
    end
    chk("idle_out_hi", 32'(hi), 32'd0);
    chk("idle_ps_pulses", 32'(ps_cnt), 32'd3);
    chk("idle_ps_shape", 32'(ps_bad), 32'd0);
    chk("idle_ovr", 32'(ovr), 32'd0);

    // Sine 0x80 at x1 -> duty 128
    wave_sel = 3'b000; amp_sel = 2'b00; sine = 8'h80;
    align(10);
    strobe();
    align(0);
    check_period("sine128", 128);
    check_period("sine128_rep", 128);
    chk("sine_ovr", 32'(ovr), 32'd0);

    // Triangle 0xC8 /4 -> 50, amp change without strobe has no effect
    wave_sel = 3'b100; amp_sel = 2'b10; tri_wave = 8'hC8;
    align(10);
    strobe();
    align(0);
    check_period("tri50", 50);
    amp_sel = 2'b11;
    check_period("tri50_a", 50);
    check_period("tri50_b", 50);
    check_period("tri50_c", 50);

    // Half 0x9A /2 -> 77
    wave_sel = 3'b010; amp_sel = 2'b01; half = 8'h9A;
    align(10);
    strobe();
    align(0);
    check_period("half77", 77);

    // Recip 0xF0 /8 -> 30
    wave_sel = 3'b011; amp_sel = 2'b11; recip = 8'hF0;
    align(10);
    strobe();
    align(0);
    check_period("recip30", 30);

    // Two strobes in one period -> overrun, second sample wins
    wave_sel = 3'b101; amp_sel = 2'b00; rect = 8'hFF;
    align(20);
    strobe();
    chk("ovr_after_first", 32'(ovr), 32'd0);
    rect = 8'h10;
    align(30);
    strobe();
    chk("ovr_set", 32'(ovr), 32'd1);
    align(0);
    check_period("rect16", 16);
    chk("ovr_sticky", 32'(ovr), 32'd1);
    do_reset();
    chk("ovr_cleared", 32'(ovr), 32'd0);
    chk("ovr_rst_ps", 32'(period_start), 32'd1);

    // Strobe on the wrap edge: old pending loads, new one waits, no overrun
    wave_sel = 3'b000; amp_sel = 2'b00; sine = 8'h40;
    align(100);
    strobe();
    sine = 8'h20;
    align(255);
    strobe();
    chk("coinc_ps", 32'(period_start), 32'd1);
    check_period("coinc64", 64);
    check_period("coinc32", 32);
    chk("coinc_ovr", 32'(ovr), 32'd0);

    // Unused select gives zero duty
    wave_sel = 3'b110; amp_sel = 2'b00;
    sine = 8'hAA; full = 8'hAA; half = 8'hAA; recip = 8'hAA; tri_wave = 8'hAA; rect = 8'hAA;
    align(10);
    strobe();
    align(0);
    check_period("sel110", 0);

    // Max duty: low exactly one cycle per period
    wave_sel = 3'b001; full = 8'hFF;
    align(10);
    strobe();
    align(0);
    check_period("full255", 255);
    check_period("full255_rep", 255);

    // Reset in the middle of a high pulse
    align(50);
    chk("mid_out_high", 32'(out), 32'd1);
    rst = 1'b0;
    step();
    tb_cnt = 0;
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_ps", 32'(period_start), 32'd1);
    rst = 1'b1;
    check_period("post_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
